// File: rtl/stack_unit.sv
// rtl/stack_unit.sv - parametrised LIFO stack with stack-machine operations and sticky error flags
module stack_unit #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [WIDTH-1:0] second,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_unf
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    OP_NOP     = 3'b000,
    OP_PUSH    = 3'b001,
    OP_POP     = 3'b010,
    OP_REPLACE = 3'b011,
    OP_DUP     = 3'b100,
    OP_SWAP    = 3'b101,
    OP_OVER    = 3'b110,
    OP_CLEAR   = 3'b111
  } op_e;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic             r_ovf;
  logic             r_unf;

  // Entry addresses wrap modulo DEPTH; when count==DEPTH the low bits are 0
  // so top-1 still lands on DEPTH-1. Reads are gated when too few entries.
  logic [AW-1:0]    w_push_idx;
  logic [AW-1:0]    w_top_idx;
  logic [AW-1:0]    w_sec_idx;
  logic             w_full;
  logic             w_empty;
  logic             w_has2;
  logic [WIDTH-1:0] w_top_val;
  logic [WIDTH-1:0] w_sec_val;

  assign w_push_idx = r_count[AW-1:0];
  assign w_top_idx  = r_count[AW-1:0] - AW'(1);
  assign w_sec_idx  = w_top_idx - AW'(1);
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_has2     = (r_count >= CW'(2));
  assign w_top_val  = r_mem[w_top_idx];
  assign w_sec_val  = r_mem[w_sec_idx];

  logic             w_wr_en;
  logic [AW-1:0]    w_wr_idx;
  logic [WIDTH-1:0] w_wr_data;
  logic             w_swap;
  logic             w_inc;
  logic             w_dec;
  logic             w_clear;
  logic             w_set_ovf;
  logic             w_set_unf;

  // Decode the op against the current occupancy; an illegal op only raises a flag
  always_comb begin
    w_wr_en   = 1'b0;
    w_wr_idx  = w_push_idx;
    w_wr_data = din;
    w_swap    = 1'b0;
    w_inc     = 1'b0;
    w_dec     = 1'b0;
    w_clear   = 1'b0;
    w_set_ovf = 1'b0;
    w_set_unf = 1'b0;
    if (en) begin
      case (op_e'(op))
        OP_PUSH: begin
          if (w_full) begin
            w_set_ovf = 1'b1;
          end else begin
            w_wr_en = 1'b1;
            w_inc   = 1'b1;
          end
        end
        OP_POP: begin
          if (w_empty) w_set_unf = 1'b1;
          else         w_dec     = 1'b1;
        end
        OP_REPLACE: begin
          if (w_empty) begin
            w_set_unf = 1'b1;
          end else begin
            w_wr_en  = 1'b1;
            w_wr_idx = w_top_idx;
          end
        end
        OP_DUP: begin
          // Missing source entry wins over full: DUP on empty is an underflow only
          if (w_empty) begin
            w_set_unf = 1'b1;
          end else if (w_full) begin
            w_set_ovf = 1'b1;
          end else begin
            w_wr_en   = 1'b1;
            w_wr_data = w_top_val;
            w_inc     = 1'b1;
          end
        end
        OP_SWAP: begin
          if (!w_has2) w_set_unf = 1'b1;
          else         w_swap    = 1'b1;
        end
        OP_OVER: begin
          if (!w_has2) begin
            w_set_unf = 1'b1;
          end else if (w_full) begin
            w_set_ovf = 1'b1;
          end else begin
            w_wr_en   = 1'b1;
            w_wr_data = w_sec_val;
            w_inc     = 1'b1;
          end
        end
        OP_CLEAR: w_clear = 1'b1;
        default: ;
      endcase
    end
  end

  // Occupancy and sticky error flags; reset and CLEAR both empty the stack
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (w_clear) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      if (w_inc)     r_count <= r_count + CW'(1);
      if (w_dec)     r_count <= r_count - CW'(1);
      if (w_set_ovf) r_ovf   <= 1'b1;
      if (w_set_unf) r_unf   <= 1'b1;
    end
  end

  // Entry storage has no reset; an op coinciding with reset is discarded
  always_ff @(posedge clk) begin
    if (reset) begin
      if (w_wr_en) r_mem[w_wr_idx] <= w_wr_data;
      if (w_swap) begin
        r_mem[w_top_idx] <= w_sec_val;
        r_mem[w_sec_idx] <= w_top_val;
      end
    end
  end

  assign top     = w_empty ? '0 : w_top_val;
  assign second  = w_has2  ? w_sec_val : '0;
  assign count   = r_count;
  assign full    = w_full;
  assign empty   = w_empty;
  assign err_ovf = r_ovf;
  assign err_unf = r_unf;

endmodule

// File: tb/tb_stack_unit.sv
// tb/tb_stack_unit.sv - self-checking bench for stack_unit against a queue model
module tb_stack_unit;

  localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, REPL = 3'd3,
                         DUP = 3'd4, SWAP = 3'd5, OVER = 3'd6, CLR = 3'd7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        a_en, b_en;
  logic [2:0]  a_op, b_op;
  logic [7:0]  a_din;
  logic [15:0] b_din;
  logic [7:0]  a_top, a_second;
  logic [15:0] b_top, b_second;
  logic [4:0]  a_count;
  logic [1:0]  b_count;
  logic        a_full, a_empty, a_ovf, a_unf;
  logic        b_full, b_empty, b_ovf, b_unf;

  stack_unit #(.WIDTH(8), .DEPTH(16)) u_a (
    .clk(clk), .reset(reset), .en(a_en), .op(a_op), .din(a_din),
    .top(a_top), .second(a_second), .count(a_count), .full(a_full),
    .empty(a_empty), .err_ovf(a_ovf), .err_unf(a_unf)
  );

  stack_unit #(.WIDTH(16), .DEPTH(2)) u_b (
    .clk(clk), .reset(reset), .en(b_en), .op(b_op), .din(b_din),
    .top(b_top), .second(b_second), .count(b_count), .full(b_full),
    .empty(b_empty), .err_ovf(b_ovf), .err_unf(b_unf)
  );

  int checks = 0;
  int errors = 0;
  bit checking = 0;

  // Model: one queue per instance, last element is the top of stack
  int m_q[2][$];
  bit m_ovf[2];
  bit m_unf[2];
  int m_dep[2] = '{16, 2};

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic void model_step(int k, logic rst, logic e, logic [2:0] o, int d);
    int n;
    int t;
    n = m_q[k].size();
    if (!rst) begin
      m_q[k].delete();
      m_ovf[k] = 0;
      m_unf[k] = 0;
      return;
    end
    if (!e) return;
    case (o)
      PUSH: if (n == m_dep[k]) m_ovf[k] = 1; else m_q[k].push_back(d);
      POP:  if (n == 0) m_unf[k] = 1; else void'(m_q[k].pop_back());
      REPL: if (n == 0) m_unf[k] = 1; else m_q[k][n-1] = d;
      DUP: begin
        if (n == 0) m_unf[k] = 1;
        else if (n == m_dep[k]) m_ovf[k] = 1;
        else m_q[k].push_back(m_q[k][n-1]);
      end
      SWAP: begin
        if (n < 2) m_unf[k] = 1;
        else begin
          t = m_q[k][n-1];
          m_q[k][n-1] = m_q[k][n-2];
          m_q[k][n-2] = t;
        end
      end
      OVER: begin
        if (n < 2) m_unf[k] = 1;
        else if (n == m_dep[k]) m_ovf[k] = 1;
        else m_q[k].push_back(m_q[k][n-2]);
      end
      CLR: begin
        m_q[k].delete();
        m_ovf[k] = 0;
        m_unf[k] = 0;
      end
      default: ;
    endcase
  endfunction

  function automatic void cmp_inst(int k, logic [31:0] t, logic [31:0] s, logic [31:0] c,
                                   logic f, logic e, logic o, logic u);
    int n;
    n = m_q[k].size();
    chk($sformatf("m%0d_top", k),    t, (n > 0) ? m_q[k][n-1] : 0);
    chk($sformatf("m%0d_second", k), s, (n > 1) ? m_q[k][n-2] : 0);
    chk($sformatf("m%0d_count", k),  c, n);
    chk($sformatf("m%0d_full", k),   {31'd0, f}, {31'd0, n == m_dep[k]});
    chk($sformatf("m%0d_empty", k),  {31'd0, e}, {31'd0, n == 0});
    chk($sformatf("m%0d_ovf", k),    {31'd0, o}, {31'd0, m_ovf[k]});
    chk($sformatf("m%0d_unf", k),    {31'd0, u}, {31'd0, m_unf[k]});
  endfunction

  always @(posedge clk) begin
    model_step(0, reset, a_en, a_op, int'(a_din));
    model_step(1, reset, b_en, b_op, int'(b_din));
  end

  always @(negedge clk) begin
    if (checking) begin
      cmp_inst(0, 32'(a_top), 32'(a_second), 32'(a_count), a_full, a_empty, a_ovf, a_unf);
      cmp_inst(1, 32'(b_top), 32'(b_second), 32'(b_count), b_full, b_empty, b_ovf, b_unf);
    end
  end

  task automatic op_a(input logic [2:0] o, input logic [7:0] d);
    @(negedge clk);
    a_en = 1'b1; a_op = o; a_din = d;
    @(posedge clk); #1;
    a_en = 1'b0;
  endtask

  task automatic op_b(input logic [2:0] o, input logic [15:0] d);
    @(negedge clk);
    b_en = 1'b1; b_op = o; b_din = d;
    @(posedge clk); #1;
    b_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    a_en = 1'b1; a_op = PUSH; a_din = 8'hAA;
    b_en = 1'b0; b_op = NOP;  b_din = 16'h0;
    @(posedge clk); #1;
    checking = 1;
    @(posedge clk); #1;
    chk("rst_count", 32'(a_count), 0);
    chk("rst_empty", {31'd0, a_empty}, 1);
    chk("rst_top",   32'(a_top), 0);
    chk("rst_ovf",   {31'd0, a_ovf}, 0);
    chk("rst_unf",   {31'd0, a_unf}, 0);

    @(negedge clk);
    reset = 1'b1; a_en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      a_op = 3'($urandom); a_din = 8'($urandom);
    end
    @(posedge clk); #1;
    chk("idle_count", 32'(a_count), 0);
    chk("idle_empty", {31'd0, a_empty}, 1);

    for (int i = 1; i <= 16; i++) op_a(PUSH, 8'(i));
    chk("fill_count",  32'(a_count), 16);
    chk("fill_full",   {31'd0, a_full}, 1);
    chk("fill_top",    32'(a_top), 32'h10);
    chk("fill_second", 32'(a_second), 32'h0F);
    op_a(PUSH, 8'hFF);
    chk("ovf_count", 32'(a_count), 16);
    chk("ovf_top",   32'(a_top), 32'h10);
    chk("ovf_flag",  {31'd0, a_ovf}, 1);
    for (int i = 0; i < 16; i++) begin
      chk("pop_value", 32'(a_top), 32'(16 - i));
      op_a(POP, 8'h00);
    end
    chk("drain_empty", {31'd0, a_empty}, 1);

    op_a(POP, 8'h00);
    chk("unf_flag",  {31'd0, a_unf}, 1);
    chk("unf_count", 32'(a_count), 0);
    op_a(PUSH, 8'h05);
    op_a(SWAP, 8'h00);
    chk("swap1_unf",   {31'd0, a_unf}, 1);
    chk("swap1_top",   32'(a_top), 5);
    chk("swap1_count", 32'(a_count), 1);
    op_a(CLR, 8'h00);
    chk("clr_ovf",   {31'd0, a_ovf}, 0);
    chk("clr_unf",   {31'd0, a_unf}, 0);
    chk("clr_count", 32'(a_count), 0);

    op_a(PUSH, 8'd3);
    op_a(PUSH, 8'd7);
    op_a(SWAP, 8'h00);
    chk("swap_top",    32'(a_top), 3);
    chk("swap_second", 32'(a_second), 7);
    op_a(OVER, 8'h00);
    chk("over_top",   32'(a_top), 7);
    chk("over_count", 32'(a_count), 3);
    op_a(DUP, 8'h00);
    chk("dup_top",    32'(a_top), 7);
    chk("dup_second", 32'(a_second), 7);
    chk("dup_count",  32'(a_count), 4);
    op_a(REPL, 8'd9);
    chk("repl_top",   32'(a_top), 9);
    chk("repl_count", 32'(a_count), 4);
    op_a(PUSH, 8'h44);
    chk("pre_rst_count", 32'(a_count), 5);

    @(negedge clk);
    reset = 1'b0; a_en = 1'b1; a_op = PUSH; a_din = 8'h22;
    @(posedge clk); #1;
    reset = 1'b1; a_en = 1'b0;
    chk("midrst_count", 32'(a_count), 0);
    chk("midrst_empty", {31'd0, a_empty}, 1);
    chk("midrst_top",   32'(a_top), 0);
    op_a(PUSH, 8'h22);
    chk("post_rst_count", 32'(a_count), 1);
    chk("post_rst_top",   32'(a_top), 32'h22);
    op_a(OVER, 8'h00);
    chk("over1_unf",   {31'd0, a_unf}, 1);
    chk("over1_count", 32'(a_count), 1);
    op_a(CLR, 8'h00);
    op_a(DUP, 8'h00);
    chk("dup0_unf", {31'd0, a_unf}, 1);
    chk("dup0_ovf", {31'd0, a_ovf}, 0);

    op_b(PUSH, 16'hBEEF);
    op_b(PUSH, 16'h1234);
    op_b(DUP, 16'h0000);
    chk("p2_ovf",    {31'd0, b_ovf}, 1);
    chk("p2_top",    32'(b_top), 32'h1234);
    chk("p2_second", 32'(b_second), 32'hBEEF);
    chk("p2_count",  32'(b_count), 2);
    op_b(OVER, 16'h0000);
    chk("p2_over_unf",   {31'd0, b_unf}, 0);
    chk("p2_over_count", 32'(b_count), 2);

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
